msg_tx_scheduler: RTL and testbench
===================================

MSG_TX_SCHEDULER -- requirements
Module: msg_tx_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, meaning queue entries (power of 2, 2..16).
REQ-002 Parameter TIMEOUT_CYC, default 1000000, meaning cycles to wait for tx_done before a retry.
REQ-003 Parameter MAX_RETRY, default 3, meaning resends after the first attempt before the message is abandoned.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 interboard_rst  in  1  synchronous flush, active-high.
REQ-007 ctrl_en  in  1  one-cycle enqueue strobe from game control.
REQ-008 ctrl_msg  in  22  {move_dir[21], block_x[20:16], block_y[15:13], msg_type[12:9], card[8:3], sel_len[2:0]}.
REQ-009 transmit  in  1  sampled with ctrl_en: 1 = send to the other board, then apply; 0 = apply locally only.
REQ-010 tx_busy  in  1  interboard transmitter is occupied.
REQ-011 tx_done  in  1  one-cycle pulse: remote Ack received for the current message.
REQ-012 tx_start  out  1  one-cycle pulse launching a transfer of tx_msg.
REQ-013 tx_msg  out  22  head entry message, 0 when the queue is empty.
REQ-014 mem_en  out  1  one-cycle apply strobe to memory handling.
REQ-015 mem_msg  out  22  equal to tx_msg; valid while mem_en=1.
REQ-016 full  out  1  queue holds DEPTH entries.
REQ-017 pending  out  $clog2(DEPTH)+1  current entry count.
REQ-018 tx_error  out  1  sticky flag: a message was abandoned.

Function
REQ-019 Each queue entry shall hold {transmit, ctrl_msg}, 23 bits, in FIFO order.
REQ-020 ctrl_en with full=0 shall write the entry at that edge; ctrl_en with full=1 and no pop in that cycle shall be dropped, leaving the queue unchanged.
REQ-021 A pop and a push in the same cycle shall both succeed, including when full=1, leaving pending unchanged.
REQ-022 The FSM shall have the states IDLE, SEND, WAIT, APPLY and ABANDON.
REQ-023 IDLE with a non-empty queue shall go to APPLY if head.transmit=0, or to SEND if head.transmit=1 and tx_busy=0; otherwise it shall stay in IDLE.
REQ-024 SEND shall assert tx_start for exactly one cycle and then go to WAIT.
REQ-025 WAIT shall go to APPLY on the cycle tx_done=1; tx_done in any other state shall be ignored.
REQ-026 APPLY shall assert mem_en for one cycle, pop the head and return to IDLE.
REQ-027 Latency: ctrl_en sampled at edge N into an empty, idle queue shall give mem_en (transmit=0) or tx_start (transmit=1) high during cycle N+2.
REQ-028 mem_en shall be high in the cycle after tx_done is sampled.
REQ-029 Local apply shall never precede the remote Ack for a transmitted message, so both boards update in the same order.
REQ-030 ABANDON shall pop the head without mem_en, set tx_error and return to IDLE.

Reset
REQ-031 rst_n=0 shall immediately clear the queue and all counters, force IDLE, and drive every output to 0.
REQ-032 interboard_rst=1 shall apply the same clear at the next edge, shall take priority over ctrl_en and tx_done, and shall abort any transfer in progress without mem_en.

Configuration
REQ-033 Macro MSG_TX_TIMEOUT_EN defined: WAIT counts cycles; on reaching TIMEOUT_CYC it returns to SEND if fewer than MAX_RETRY resends have occurred, else it goes to ABANDON; the counter clears on each SEND.
REQ-034 MSG_TX_TIMEOUT_EN undefined: WAIT waits indefinitely, ABANDON is unreachable, tx_error is tied to 0, and the timeout counters are not built.

Structure
REQ-035 Package msg_tx_pkg shall hold the state enum, MSG_W=22, the field offset constants and the 23-bit entry typedef.
REQ-036 The queue shall be a sub-module msg_fifo (DEPTH x 23, push/pop/count/full/empty); all sequencing logic shall stay in msg_tx_scheduler.

Verification
REQ-037 Local apply: ctrl_en at edge 10 with transmit=0 and msg=0x2A5F1 -> mem_en=1 in cycle 12, mem_msg=0x2A5F1, tx_start never asserted.
REQ-038 Remote send: transmit=1 and tx_busy=0 -> tx_start in cycle N+2; tx_done 30 cycles later -> mem_en on the next cycle; tx_done while IDLE -> no effect.
REQ-039 Ordering and full: 5 back-to-back ctrl_en with DEPTH=4 and tx_busy=1 -> full=1, 5th dropped, pending=4; releasing tx_busy -> 4 tx_start/mem_en pairs in entry order.
REQ-040 Push on pop at full: ctrl_en in the APPLY cycle with pending=4 -> accepted, pending stays 4.
REQ-041 Timeout (macro on, TIMEOUT_CYC=16, MAX_RETRY=2): no tx_done -> 3 tx_start pulses 17 cycles apart, then tx_error=1, entry dropped with no mem_en.
REQ-042 Flush: interboard_rst during WAIT with pending=3 -> next cycle pending=0, IDLE, all outputs 0, a later tx_done is ignored.

Source files
------------

// File: rtl/msg_tx_pkg.sv
// Shared types and constants for the inter-board message transmit scheduler.
// The optional retry/abandon behaviour is enabled with the macro MSG_TX_TIMEOUT_EN.
package msg_tx_pkg;

    localparam int MSG_W   = 22;
    localparam int ENTRY_W = MSG_W + 1;

    // Field positions inside ctrl_msg
    localparam int MOVE_DIR_BIT = 21;
    localparam int BLOCK_X_LSB  = 16;
    localparam int BLOCK_X_W    = 5;
    localparam int BLOCK_Y_LSB  = 13;
    localparam int BLOCK_Y_W    = 3;
    localparam int MSG_TYPE_LSB = 9;
    localparam int MSG_TYPE_W   = 4;
    localparam int CARD_LSB     = 3;
    localparam int CARD_W       = 6;
    localparam int SEL_LEN_LSB  = 0;
    localparam int SEL_LEN_W    = 3;

    typedef struct packed {
        logic             transmit;
        logic [MSG_W-1:0] msg;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_APPLY   = 3'd3,
        ST_ABANDON = 3'd4
    } state_t;

endpackage

// File: rtl/msg_fifo.sv
// DEPTH-entry FIFO of scheduler entries; a push is accepted at full when a pop
// happens in the same cycle, and srst empties the queue at the next edge.
module msg_fifo
    import msg_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     srst,
    input  logic                     push,
    input  entry_t                   din,
    input  logic                     pop,
    output entry_t                   dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    entry_t          mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            pop_ok_s;
    logic            push_ok_s;

    assign empty     = (count_r == '0);
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s && !srst) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Queues game-control messages, sends transmitted ones to the other board and
// applies each locally only after its remote Ack. Optional macro: MSG_TX_TIMEOUT_EN.
module msg_tx_scheduler
    import msg_tx_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     interboard_rst,
    input  logic                     ctrl_en,
    input  logic [MSG_W-1:0]         ctrl_msg,
    input  logic                     transmit,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [MSG_W-1:0]         tx_msg,
    output logic                     mem_en,
    output logic [MSG_W-1:0]         mem_msg,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     tx_error
);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
        TIMEOUT_CYC < 1 || MAX_RETRY < 0) begin : g_param_check
        $error("msg_tx_scheduler: illegal parameter set");
    end

    state_t  state_r;
    state_t  next_state_s;
    entry_t  head_s;
    entry_t  din_s;
    logic    empty_s;
    logic    pop_s;
    logic    tx_start_r;
    logic    mem_en_r;

    assign din_s = '{transmit: transmit, msg: ctrl_msg};
    assign pop_s = (state_r == ST_APPLY) || (state_r == ST_ABANDON);

    msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (interboard_rst),
        .push  (ctrl_en),
        .din   (din_s),
        .pop   (pop_s),
        .dout  (head_s),
        .count (pending),
        .full  (full),
        .empty (empty_s)
    );

`ifdef MSG_TX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    logic [TMR_W-1:0] timer_r;
    logic [RTY_W-1:0] retry_r;
    logic             timeout_s;
    logic             retry_left_s;
    logic             tx_error_r;

    assign timeout_s    = (timer_r == TMR_W'(TIMEOUT_CYC - 1));
    assign retry_left_s = (retry_r < RTY_W'(MAX_RETRY));
    assign tx_error     = tx_error_r;

    // Wait-for-Ack timer restarts on every launch; resend count restarts per message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= '0;
            retry_r <= '0;
        end else if (interboard_rst) begin
            timer_r <= '0;
            retry_r <= '0;
        end else begin
            if (state_r == ST_WAIT) begin
                timer_r <= timer_r + 1'b1;
            end else begin
                timer_r <= '0;
            end
            if (state_r == ST_IDLE) begin
                retry_r <= '0;
            end else if (state_r == ST_WAIT && next_state_s == ST_SEND) begin
                retry_r <= retry_r + 1'b1;
            end else begin
                retry_r <= retry_r;
            end
        end
    end

    // Sticky abandon flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_error_r <= 1'b0;
        end else if (interboard_rst) begin
            tx_error_r <= 1'b0;
        end else if (next_state_s == ST_ABANDON) begin
            tx_error_r <= 1'b1;
        end else begin
            tx_error_r <= tx_error_r;
        end
    end
`else
    assign tx_error = 1'b0;
`endif

    // Next-state logic; a transmitted message is applied only once its Ack arrives
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (empty_s) begin
                    next_state_s = ST_IDLE;
                end else if (!head_s.transmit) begin
                    next_state_s = ST_APPLY;
                end else if (!tx_busy) begin
                    next_state_s = ST_SEND;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    next_state_s = ST_APPLY;
                end else begin
`ifdef MSG_TX_TIMEOUT_EN
                    if (timeout_s) begin
                        if (retry_left_s) begin
                            next_state_s = ST_SEND;
                        end else begin
                            next_state_s = ST_ABANDON;
                        end
                    end else begin
                        next_state_s = ST_WAIT;
                    end
`else
                    next_state_s = ST_WAIT;
`endif
                end
            end
            ST_APPLY:   next_state_s = ST_IDLE;
            ST_ABANDON: next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // State register; flush aborts any transfer without applying it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (interboard_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Strobes registered alongside the state so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_r <= 1'b0;
            mem_en_r   <= 1'b0;
        end else if (interboard_rst) begin
            tx_start_r <= 1'b0;
            mem_en_r   <= 1'b0;
        end else begin
            tx_start_r <= (next_state_s == ST_SEND);
            mem_en_r   <= (next_state_s == ST_APPLY);
        end
    end

    assign tx_start = tx_start_r;
    assign mem_en   = mem_en_r;
    assign tx_msg   = empty_s ? {MSG_W{1'b0}} : head_s.msg;
    assign mem_msg  = tx_msg;

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Directed bench for msg_tx_scheduler with a scoreboard of queued entries.
module tb_msg_tx_scheduler;
    import msg_tx_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              interboard_rst;
    logic              ctrl_en;
    logic [MSG_W-1:0]  ctrl_msg;
    logic              transmit;
    logic              tx_busy;
    logic              tx_done;
    logic              tx_start;
    logic [MSG_W-1:0]  tx_msg;
    logic              mem_en;
    logic [MSG_W-1:0]  mem_msg;
    logic              full;
    logic [2:0]        pending;
    logic              tx_error;

    int n_vec;
    int n_err;
    int n_start;
    int n_mem;
    int cyc;
    bit seen_start;
    bit seen_done;
    bit err_seen;
    entry_t exp_q[$];

    msg_tx_scheduler #(
        .DEPTH       (4),
        .TIMEOUT_CYC (16),
        .MAX_RETRY   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .interboard_rst (interboard_rst),
        .ctrl_en        (ctrl_en),
        .ctrl_msg       (ctrl_msg),
        .transmit       (transmit),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_start       (tx_start),
        .tx_msg         (tx_msg),
        .mem_en         (mem_en),
        .mem_msg        (mem_msg),
        .full           (full),
        .pending        (pending),
        .tx_error       (tx_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every launch and every apply must match the queue head
    always @(negedge clk) begin
        entry_t e;
        if (!rst_n || interboard_rst) begin
            exp_q.delete();
            seen_start = 1'b0;
            seen_done  = 1'b0;
        end else begin
            if (tx_start) begin
                n_start++;
                check("start_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    check("start_msg", 32'(tx_msg), 32'(exp_q[0].msg));
                    check("start_is_tx", 32'(exp_q[0].transmit), 32'd1);
                end
                seen_start = 1'b1;
                seen_done  = 1'b0;
            end else if (tx_done && seen_start) begin
                seen_done = 1'b1;
            end
            if (mem_en) begin
                n_mem++;
                check("mem_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("mem_msg", 32'(mem_msg), 32'(e.msg));
                    if (e.transmit) begin
                        check("apply_after_ack", 32'(seen_start && seen_done), 32'd1);
                    end
                end
                seen_start = 1'b0;
                seen_done  = 1'b0;
            end
            if (tx_error && !err_seen) begin
                err_seen = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                end
                seen_start = 1'b0;
            end
        end
    end

    task automatic do_push(input logic tr, input logic [MSG_W-1:0] m, input bit accept);
        entry_t e;
        ctrl_en  = 1'b1;
        transmit = tr;
        ctrl_msg = m;
        e.transmit = tr;
        e.msg      = m;
        if (accept) exp_q.push_back(e);
        @(posedge clk);
        #1;
        ctrl_en  = 1'b0;
        transmit = 1'b0;
        ctrl_msg = '0;
    endtask

    task automatic wait_start(input int budget, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!tx_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(tx_start), 32'd1);
    endtask

    task automatic send_ack(input string tag);
        wait_start(20, tag);
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int s1;
        int s2;
        int s3;
        int k;
        int mem_snap;
        int start_snap;
        n_vec = 0; n_err = 0; n_start = 0; n_mem = 0;
        seen_start = 1'b0; seen_done = 1'b0; err_seen = 1'b0;
        rst_n = 1'b0; interboard_rst = 1'b0; ctrl_en = 1'b0; ctrl_msg = '0;
        transmit = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;

        // Reset state
        #12;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_outputs", 32'({tx_msg, mem_msg, full, tx_error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Local apply: two-edge latency, no launch
        do_push(1'b0, 22'h2A5F1, 1'b1);
        @(negedge clk);
        check("local_early", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("local_mem_en", 32'(mem_en), 32'd1);
        check("local_mem_msg", 32'(mem_msg), 32'h2A5F1);
        check("local_no_start", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("local_mem_en_pulse", 32'(mem_en), 32'd0);
        check("local_starts", 32'(n_start), 32'd0);
        @(posedge clk); #1;

        // Remote send, Ack 30 cycles later, then stray Ack while idle
        do_push(1'b1, 22'h15A3C, 1'b1);
        @(negedge clk);
        check("remote_early", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("remote_start", 32'(tx_start), 32'd1);
        check("remote_tx_msg", 32'(tx_msg), 32'h15A3C);
        @(negedge clk);
        check("remote_start_pulse", 32'(tx_start), 32'd0);
        repeat (29) @(posedge clk);
        #1;
        check("remote_no_early_apply", 32'(mem_en), 32'd0);
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        @(negedge clk);
        check("remote_mem_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        check("remote_pending", 32'(pending), 32'd0);
        mem_snap = n_mem; start_snap = n_start;
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done_mem", 32'(n_mem), 32'(mem_snap));
        check("idle_done_start", 32'(n_start), 32'(start_snap));
        @(posedge clk); #1;

        // Ordering and full: fifth push dropped
        tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_push(1'b1, 22'h30000 + 22'(i * 17), (i < 4));
        end
        @(negedge clk);
        check("full_flag", 32'(full), 32'd1);
        check("full_pending", 32'(pending), 32'd4);
        check("full_head", 32'(tx_msg), 32'h30000);
        check("busy_no_start", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        tx_busy = 1'b0;

        // Push while the head is applied at full
        wait_start(20, "pop_push_start");
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        do_push(1'b1, 22'h0ABCD, 1'b1);
        check("pop_push_pending", 32'(pending), 32'd4);
        check("pop_push_full", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send_ack("drain");
        end
        @(negedge clk);
        check("drain_pending", 32'(pending), 32'd0);
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;

        // Flush during WAIT with three entries queued
        do_push(1'b1, 22'h11111, 1'b1);
        do_push(1'b1, 22'h22222, 1'b1);
        do_push(1'b0, 22'h33333, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("flush_pre_pending", 32'(pending), 32'd3);
        @(posedge clk); #1;
        interboard_rst = 1'b1;
        ctrl_en = 1'b1; ctrl_msg = 22'h3FFFF; transmit = 1'b0;
        @(posedge clk); #1;
        interboard_rst = 1'b0;
        ctrl_en = 1'b0; ctrl_msg = '0;
        @(negedge clk);
        check("flush_pending", 32'(pending), 32'd0);
        check("flush_outputs", 32'({tx_start, mem_en, full, tx_error}), 32'd0);
        check("flush_msgs", 32'({tx_msg, mem_msg}), 32'd0);
        mem_snap = n_mem; start_snap = n_start;
        @(posedge clk); #1;
        tx_done = 1'b1;
        @(posedge clk); #1;
        tx_done = 1'b0;
        repeat (4) @(negedge clk);
        check("flush_done_mem", 32'(n_mem), 32'(mem_snap));
        check("flush_done_start", 32'(n_start), 32'(start_snap));
        check("flush_done_pending", 32'(pending), 32'd0);
        @(posedge clk); #1;

`ifdef MSG_TX_TIMEOUT_EN
        // Timeout: three launches 17 cycles apart, then abandon
        mem_snap = n_mem;
        do_push(1'b1, 22'h2BEEF, 1'b1);
        wait_start(10, "to_start1");
        s1 = cyc;
        wait_start(30, "to_start2");
        s2 = cyc;
        wait_start(30, "to_start3");
        s3 = cyc;
        check("to_gap1", 32'(s2 - s1), 32'd17);
        check("to_gap2", 32'(s3 - s2), 32'd17);
        k = 0;
        while (!tx_error && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_error", 32'(tx_error), 32'd1);
        @(negedge clk);
        check("to_pending", 32'(pending), 32'd0);
        check("to_no_mem", 32'(n_mem), 32'(mem_snap));
        check("to_sticky", 32'(tx_error), 32'd1);
`else
        check("no_timeout_error", 32'(tx_error), 32'd0);
`endif

        check("total_mem_en", 32'(n_mem), 32'd7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
